// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin arbiter/sequencer sharing one external 4-bit ALU
// between two requesters over valid/ready command and response channels.
// Optional feature macro: ALU_RR_ARBITER_STATS_EN adds saturating per-requester
// grant counters gnt0_cnt/gnt1_cnt.
module alu_rr_arbiter #(
    parameter int unsigned W   = 4,   // fixed to the ALU width
    parameter int unsigned OPW = 3    // ALU opcode select width
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [OPW-1:0] req0_op,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [OPW-1:0] req1_op,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    output logic           resp0_valid,
    input  logic           resp0_ready,
    output logic           resp1_valid,
    input  logic           resp1_ready,
    output logic [W-1:0]   resp_sum,
    output logic           resp_carry,
    output logic           resp_zero,
    output logic           resp_flow,
    output logic [OPW-1:0] alu_op,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    input  logic [W-1:0]   alu_sum,
    input  logic           alu_carry,
    input  logic           alu_zero,
    input  logic           alu_flow
`ifdef ALU_RR_ARBITER_STATS_EN
    ,
    output logic [7:0]     gnt0_cnt,
    output logic [7:0]     gnt1_cnt
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state;
    logic [1:0] state_n;
    logic       prio;      // requester favoured on a tie
    logic       g;         // requester owning the in-flight operation
    logic       accept;
    logic       acc_id;
    logic       resp_hs;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, grant decision and combinational command ready.
    always_comb begin
        state_n    = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        acc_id     = 1'b0;
        resp_hs    = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid && (!req1_valid || !prio)) begin
                    req0_ready = 1'b1;
                    accept     = 1'b1;
                    acc_id     = 1'b0;
                    state_n    = EXEC;
                end else if (req1_valid) begin
                    req1_ready = 1'b1;
                    accept     = 1'b1;
                    acc_id     = 1'b1;
                    state_n    = EXEC;
                end
            end
            EXEC: begin
                state_n = RESP;
            end
            RESP: begin
                resp_hs = g ? resp1_ready : resp0_ready;
                if (resp_hs) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Command latch into the ALU, result capture and response valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_op      <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            g           <= 1'b0;
            prio        <= 1'b0;
            resp_sum    <= '0;
            resp_carry  <= 1'b0;
            resp_zero   <= 1'b0;
            resp_flow   <= 1'b0;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
        end else begin
            if (accept) begin
                alu_op <= acc_id ? req1_op : req0_op;
                alu_a  <= acc_id ? req1_a  : req0_a;
                alu_b  <= acc_id ? req1_b  : req0_b;
                g      <= acc_id;
                prio   <= ~acc_id;
            end
            if (state == EXEC) begin
                resp_sum    <= alu_sum;
                resp_carry  <= alu_carry;
                resp_zero   <= alu_zero;
                resp_flow   <= alu_flow;
                resp0_valid <= ~g;
                resp1_valid <= g;
            end
            if (resp_hs) begin
                resp0_valid <= 1'b0;
                resp1_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_RR_ARBITER_STATS_EN
    // Saturating accept counters per requester.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt0_cnt <= 8'd0;
            gnt1_cnt <= 8'd0;
        end else if (accept) begin
            if (!acc_id && gnt0_cnt != 8'hFF) begin
                gnt0_cnt <= gnt0_cnt + 8'd1;
            end
            if (acc_id && gnt1_cnt != 8'hFF) begin
                gnt1_cnt <= gnt1_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: directed and randomized checks of alu_rr_arbiter against
// a transaction-level model; the bench also plays the role of the ALU.
module tb_alu_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [2:0] req0_op = 3'd0, req1_op = 3'd0;
    logic [3:0] req0_a = 4'd0, req0_b = 4'd0, req1_a = 4'd0, req1_b = 4'd0;
    logic       resp0_valid, resp1_valid;
    logic       resp0_ready = 1'b1, resp1_ready = 1'b1;
    logic [3:0] resp_sum;
    logic       resp_carry, resp_zero, resp_flow;
    logic [2:0] alu_op;
    logic [3:0] alu_a, alu_b, alu_sum;
    logic       alu_carry, alu_zero, alu_flow;
`ifdef ALU_RR_ARBITER_STATS_EN
    logic [7:0] gnt0_cnt, gnt1_cnt;
`endif

    int total = 0;
    int bad   = 0;

    alu_rr_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_sum(resp_sum), .resp_carry(resp_carry), .resp_zero(resp_zero),
        .resp_flow(resp_flow),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_sum(alu_sum), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .alu_flow(alu_flow)
`ifdef ALU_RR_ARBITER_STATS_EN
        , .gnt0_cnt(gnt0_cnt), .gnt1_cnt(gnt1_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference ALU: returns {sum, carry, zero, flow}.
    function automatic logic [6:0] alu_fn(input logic [2:0] op, input logic [3:0] a,
                                          input logic [3:0] b);
        logic [4:0] t;
        logic [3:0] s;
        logic       c, f;
        c = 1'b0;
        f = 1'b0;
        t = {1'b0, a} + {1'b0, b};
        case (op)
            3'd0: begin s = t[3:0]; c = t[4]; f = (a[3] == b[3]) && (s[3] != a[3]); end
            3'd1: begin s = a - b; c = (a < b); f = (a[3] != b[3]) && (s[3] != a[3]); end
            3'd2: s = ~a;
            3'd3: s = a & b;
            3'd4: s = a | b;
            3'd5: s = a ^ b;
            3'd6: s = ($signed(a) > $signed(b)) ? 4'd1 : 4'd0;
            default: s = (a == b) ? 4'd1 : 4'd0;
        endcase
        return {s, c, (s == 4'd0), f};
    endfunction

    // The bench acts as the combinational ALU behind the arbiter.
    always_comb {alu_sum, alu_carry, alu_zero, alu_flow} = alu_fn(alu_op, alu_a, alu_b);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Transaction model: an op is accepted in an idle cycle, its response is
    // valid from two edges after acceptance until the owner takes it.
    logic       m_busy = 1'b0;
    logic       m_exec = 1'b0;   // first cycle after acceptance, no response yet
    logic       m_owner = 1'b0;
    logic       m_prio = 1'b0;
    logic [2:0] m_op = 3'd0;
    logic [3:0] m_a = 4'd0, m_b = 4'd0;
    logic [6:0] m_res = 7'd0;

    always @(negedge clk) begin
        logic e_r0, e_r1, e_v0, e_v1;
        if (!rst) begin
            chk("reset_outputs", 32'({req0_ready, req1_ready, resp0_valid, resp1_valid,
                resp_sum, resp_carry, resp_zero, resp_flow, alu_op, alu_a, alu_b}), 32'd0);
            m_busy = 1'b0; m_exec = 1'b0; m_owner = 1'b0; m_prio = 1'b0;
            m_op = 3'd0; m_a = 4'd0; m_b = 4'd0; m_res = 7'd0;
        end else begin
            e_r0 = !m_busy && req0_valid && (!req1_valid || !m_prio);
            e_r1 = !m_busy && req1_valid && !e_r0;
            e_v0 = m_busy && !m_exec && !m_owner;
            e_v1 = m_busy && !m_exec && m_owner;
            chk("model_ready", 32'({req0_ready, req1_ready}), 32'({e_r0, e_r1}));
            chk("model_resp_valid", 32'({resp0_valid, resp1_valid}), 32'({e_v0, e_v1}));
            chk("model_alu_regs", 32'({alu_op, alu_a, alu_b}), 32'({m_op, m_a, m_b}));
            chk("model_resp_data", 32'({resp_sum, resp_carry, resp_zero, resp_flow}),
                32'(m_res));
            if (!m_busy) begin
                if (e_r0 || e_r1) begin
                    m_busy  = 1'b1;
                    m_exec  = 1'b1;
                    m_owner = e_r1;
                    m_prio  = ~e_r1;
                    m_op    = e_r1 ? req1_op : req0_op;
                    m_a     = e_r1 ? req1_a  : req0_a;
                    m_b     = e_r1 ? req1_b  : req0_b;
                end
            end else if (m_exec) begin
                m_exec = 1'b0;
                m_res  = alu_fn(m_op, m_a, m_b);
            end else if (m_owner ? resp1_ready : resp0_ready) begin
                m_busy = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig_of(input int who);
        case (who)
            0: return req0_ready;
            1: return req1_ready;
            2: return resp0_valid;
            default: return resp1_valid;
        endcase
    endfunction

    // Wait (bounded) for a ready/valid; returns at the negedge where it is seen.
    task automatic await_sig(input int who, input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!sig_of(who) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(sig_of(who)), 32'd1);
    endtask

    task automatic do_reset();
        step();
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        step();
        rst = 1'b1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic a0, a1;
        int n0, n1;
        @(negedge clk);
        step();
        rst = 1'b1;

        // Single add from requester 0.
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 4'b0111; req0_b = 4'b0001;
        @(negedge clk);
        chk("t1_ready0", 32'({req0_ready, req1_ready}), 32'b10);
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        chk("t1_exec_no_valid", 32'(resp0_valid), 32'd0);
        step();
        @(negedge clk);
        chk("t1_resp_valid", 32'({resp0_valid, resp1_valid}), 32'b10);
        chk("t1_resp_data", 32'({resp_sum, resp_carry, resp_zero, resp_flow}), 32'b1000_0_0_1);
        step();
        @(negedge clk);
        chk("t1_valid_dropped", 32'(resp0_valid), 32'd0);

        // Single sub from requester 1.
        step();
        req1_valid = 1'b1; req1_op = 3'd1; req1_a = 4'b0011; req1_b = 4'b0101;
        @(negedge clk);
        chk("t2_ready1", 32'({req0_ready, req1_ready}), 32'b01);
        step();
        req1_valid = 1'b0;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("t2_resp_valid", 32'({resp0_valid, resp1_valid}), 32'b01);
        chk("t2_resp_data", 32'({resp_sum, resp_carry, resp_zero, resp_flow}), 32'b1110_1_0_0);
        step();

        // Both valid from reset, held: grants alternate 0,1,0.
        do_reset();
        req0_valid = 1'b1; req0_op = 3'd7; req0_a = 4'b0101; req0_b = 4'b0101;
        req1_valid = 1'b1; req1_op = 3'd3; req1_a = 4'b1010; req1_b = 4'b0101;
        await_sig(0, "t3_grant0_first");
        chk("t3_only_ready0", 32'(req1_ready), 32'd0);
        await_sig(2, "t3_resp0");
        chk("t3_resp0_data", 32'({resp_sum, resp_zero}), 32'b0001_0);
        await_sig(1, "t3_grant1_second");
        chk("t3_only_ready1", 32'(req0_ready), 32'd0);
        await_sig(3, "t3_resp1");
        chk("t3_resp1_data", 32'({resp_sum, resp_zero}), 32'b0000_1);
        await_sig(0, "t3_grant0_third");
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        settle(4);

        // Backpressure on response 0 while requester 1 waits.
        resp0_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 3'd4; req0_a = 4'b0101; req0_b = 4'b0010;
        await_sig(0, "t4_grant0");
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = 3'd5; req1_a = 4'b1001; req1_b = 4'b0011;
        await_sig(2, "t4_resp0");
        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk);
            chk("t4_hold_valid", 32'(resp0_valid), 32'd1);
            chk("t4_hold_data", 32'({resp_sum, resp_carry, resp_zero, resp_flow}), 32'b0111_0_0_0);
            chk("t4_req1_blocked", 32'(req1_ready), 32'd0);
        end
        step();
        resp0_ready = 1'b1;
        @(negedge clk);
        chk("t4_req1_still_blocked", 32'(req1_ready), 32'd0);
        step();
        @(negedge clk);
        chk("t4_req1_accepted", 32'(req1_ready), 32'd1);
        step();
        req1_valid = 1'b0;
        settle(4);

        // Reset pulse during EXEC of a req0 xor.
        req0_valid = 1'b1; req0_op = 3'd5; req0_a = 4'b1100; req0_b = 4'b1010;
        await_sig(0, "t5_grant0");
        step();
        rst = 1'b0;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("t5_zero_in_exec", 32'({resp0_valid, alu_op, alu_a, alu_b}), 32'd0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t5_no_resp", 32'({resp0_valid, resp1_valid}), 32'd0);
            step();
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        await_sig(0, "t5_prio_reset");
        chk("t5_ready1_low", 32'(req1_ready), 32'd0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        settle(4);

`ifdef ALU_RR_ARBITER_STATS_EN
        // Counter saturation: 300 req0 accepts, 3 req1 accepts.
        do_reset();
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        n0 = 0;
        req0_valid = 1'b1;
        for (int i = 0; i < 2000 && n0 < 300; i++) begin
            @(negedge clk);
            if (req0_ready) n0++;
            step();
            if (n0 == 300) req0_valid = 1'b0;
        end
        chk("stats_req0_accepts", 32'(n0), 32'd300);
        n1 = 0;
        req1_valid = 1'b1;
        for (int i = 0; i < 100 && n1 < 3; i++) begin
            @(negedge clk);
            if (req1_ready) n1++;
            step();
            if (n1 == 3) req1_valid = 1'b0;
        end
        chk("stats_req1_accepts", 32'(n1), 32'd3);
        settle(4);
        @(negedge clk);
        chk("stats_gnt0_sat", 32'(gnt0_cnt), 32'd255);
        chk("stats_gnt1", 32'(gnt1_cnt), 32'd3);
        step();
`endif

        // Randomized traffic, commands held until accepted.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            a0 = req0_ready;
            a1 = req1_ready;
            step();
            if (!(req0_valid && !a0)) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_op = 3'($urandom_range(0, 7));
                req0_a  = 4'($urandom_range(0, 15));
                req0_b  = 4'($urandom_range(0, 15));
            end
            if (!(req1_valid && !a1)) begin
                req1_valid = ($urandom_range(0, 3) != 0);
                req1_op = 3'($urandom_range(0, 7));
                req1_a  = 4'($urandom_range(0, 15));
                req1_b  = 4'($urandom_range(0, 15));
            end
            resp0_ready = ($urandom_range(0, 2) != 0);
            resp1_ready = ($urandom_range(0, 2) != 0);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single 4-bit ALU datapath between two requesters.
- Each requester issues op/a/b over a valid/ready request channel and gets sum/carry/zero/flow back on its own valid/ready response channel.
- The block sits between the requesters and the ALU. It drives the ALU opcode/operand inputs from registers and samples the ALU's combinational result.

Parameters:
W, 4, operand/result width (fixed to ALU width; no other value supported)
OPW, 3, opcode width (ALU opcode select bits [2:0])

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
req0_valid  input  1  requester 0 command valid
req0_ready  output  1  requester 0 command accepted this cycle
req0_op  input  3  requester 0 opcode
req0_a  input  4  requester 0 operand a (signed)
req0_b  input  4  requester 0 operand b (signed)
req1_valid/req1_ready/req1_op/req1_a/req1_b  same as requester 0, for requester 1
resp0_valid  output  1  response for requester 0 valid
resp0_ready  input  1  requester 0 takes response
resp1_valid  output  1  response for requester 1 valid
resp1_ready  input  1  requester 1 takes response
resp_sum  output  4  shared registered result; meaningful only with the asserted respN_valid
resp_carry/resp_zero/resp_flow  output  1 each  shared registered flags
alu_op  output  3  to ALU opcode select
alu_a  output  4  to ALU a
alu_b  output  4  to ALU b
alu_sum  input  4  from ALU
alu_carry/alu_zero/alu_flow  input  1 each  from ALU

Behaviour:
- Opcodes (pass-through, not decoded): 000 add, 001 sub, 010 not a, 011 and, 100 or, 101 xor, 110 a>b, 111 a==b.
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values: all outputs 0; round-robin pointer prio=0 (requester 0 favoured); grant register g=0.
- IDLE:
  - If no valid: stay.
  - If one valid: grant that requester.
  - If both valid: grant requester prio.
  - The granted reqN_ready is asserted combinationally in that same cycle; the other ready stays 0.
  - On the clock edge: latch op/a/b into alu_op/alu_a/alu_b, set g=N, set prio=~N, go to EXEC.
- reqN_ready is 0 in EXEC and RESP. Commands are accepted only in IDLE.
- EXEC: exactly one cycle; the ALU settles from the registered inputs. At the end of the cycle, capture alu_sum/carry/zero/flow into resp_*, assert respg_valid, go to RESP.
- RESP:
  - respg_valid and resp_* are held stable until respg_ready=1.
  - On the handshake edge: drop valid and go to IDLE.
  - alu_op/a/b hold their last values. Only the granted response valid is ever high.
- Latency: accept edge -> resp valid 2 cycles later. Minimum 3 cycles per operation.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1...
- A requester deasserting valid in the accept cycle is a protocol violation and is not handled.
- Reset asserted mid-operation (any state): immediately returns to IDLE with all outputs 0. The in-flight command is discarded and no response is produced.

Optional Feature:
ALU_RR_ARBITER_STATS_EN
- Defined: adds outputs gnt0_cnt[7:0] and gnt1_cnt[7:0].
  - Each counter increments on every accept for its requester and saturates at 255.
  - Both counters reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then req0 add a=0111 b=0001 -> req0_ready same cycle; resp0_valid 2 cycles later with sum=1000, carry=0, flow=1, zero=0.
- req1 sub a=0011 b=0101 -> resp1_valid with sum=1110, carry=1, flow=0, zero=0; resp0_valid stays 0.
- Both valid from reset, held: req0 op=111 a=b=0101, req1 op=011 a=1010 b=0101.
  - Order is grant 0 then 1.
  - Responses: sum=0001 zero=0, then sum=0000 zero=1.
  - Continued valid keeps alternating.
- Backpressure: resp0_ready low for 5 cycles with req1_valid high.
  - resp0_valid and resp_* stay stable; req1_ready stays 0.
  - One cycle after resp0_ready rises: req1 is accepted.
- Reset pulse during EXEC of req0 xor -> all outputs 0 immediately; no resp0_valid after release; next simultaneous request is granted to requester 0.
- With ALU_RR_ARBITER_STATS_EN, 300 req0 accepts and 3 req1 accepts -> gnt0_cnt=255 (saturated), gnt1_cnt=3.
